// File: rtl/shift_pkg.sv
// shift_pkg: shift mode encodings and width/legality helpers shared by the shifter
package shift_pkg;
  typedef enum logic [1:0] {LSR = 2'b00, LSL = 2'b01, ASR = 2'b10, ROR = 2'b11} mode_e;
  function automatic int shamt_w(input int n);
    return $clog2(n);
  endfunction
  function automatic bit legal_n(input int n);
    return n >= 4 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one pipeline stage shifting by D when shamt bit log2(D) is set, then registering
module shift_stage
  import shift_pkg::*;
#(
  parameter int N = 16,
  parameter int D = 1,
  localparam int S = shamt_w(N),
  localparam int K = $clog2(D)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  input  logic [S-1:0] i_shamt,
  input  mode_e        i_mode,
  output logic         o_valid,
  output logic [N-1:0] o_data,
  output logic [S-1:0] o_shamt,
  output mode_e        o_mode
);
  logic [D-1:0] w_fill;
  logic [N-1:0] w_sh;
  logic [N-1:0] w_next;
  always_comb begin
    w_fill = i_mode == ROR ? i_data[D-1:0] : i_mode == ASR ? {D{i_data[N-1]}} : '0;
    w_sh   = i_mode == LSL ? {i_data[N-1-D:0], {D{1'b0}}} : {w_fill, i_data[N-1:D]};
    w_next = i_shamt[K] ? w_sh : i_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_shamt <= '0;
      o_mode  <= LSR;
    end else if (en) begin
      o_valid <= i_valid;
      o_data  <= w_next;
      o_shamt <= i_shamt;
      o_mode  <= i_mode;
    end
  end
endmodule

// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter: S-stage pipelined barrel shifter (LSR/LSL/ASR/ROR) with global stall
module pipe_barrel_shifter
  import shift_pkg::*;
#(
  parameter int N = 16,
  localparam int S = shamt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_shamt,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);
  if (!legal_n(N)) begin : g_bad_n
    $error("pipe_barrel_shifter: N must be a power of two and at least 4");
  end
  logic         w_stall;
  logic         w_valid [S+1];
  logic [N-1:0] w_data  [S+1];
  logic [S-1:0] w_shamt [S+1];
  mode_e        w_mode  [S+1];
  assign w_stall    = out_valid & ~out_ready;
  assign in_ready   = ~w_stall;
  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_mode[0]  = mode_e'(in_mode);
  for (genvar k = 0; k < S; k++) begin : g_stage
    shift_stage #(.N(N), .D(1 << k)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (~w_stall),
      .i_valid(w_valid[k]),
      .i_data (w_data[k]),
      .i_shamt(w_shamt[k]),
      .i_mode (w_mode[k]),
      .o_valid(w_valid[k+1]),
      .o_data (w_data[k+1]),
      .o_shamt(w_shamt[k+1]),
      .o_mode (w_mode[k+1])
    );
  end
  assign out_valid = w_valid[S];
  assign out_data  = w_data[S];
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter: table vectors plus scoreboard-checked streaming, backpressure and reset sequences
module tb_pipe_barrel_shifter;
  import shift_pkg::*;
  typedef struct {
    logic [15:0] exp;
    int          cyc;
  } sb_t;
  typedef struct {
    logic [15:0] d;
    logic [3:0]  sh;
    logic [1:0]  m;
    logic [15:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  sb_t         q[$];
  vec_t        v[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [15:0] drv_exp = '0;
  logic [15:0] held;
  logic [15:0] rd;
  logic [3:0]  rs;
  logic [1:0]  rm;
  bit          acc = 1'b0;
  bit          lat_chk = 1'b1;
  bit          rnd_rdy = 1'b0;
  pipe_barrel_shifter #(.N(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end
  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] m);
    logic [15:0] r;
    int s;
    for (int i = 0; i < 16; i++) begin
      s = (m == 2'b01) ? i - int'(sh) : i + int'(sh);
      if (m == 2'b11) s = s % 16;
      r[i] = (s >= 0 && s < 16) ? d[s] : (m == 2'b10 ? d[15] : 1'b0);
    end
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    sb_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_out: got %h, required no output", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.exp));
          if (lat_chk) chk("latency", cyc - e.cyc, 4);
        end
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{drv_exp, cyc});
        acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] m, input logic [15:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    drv_exp  = e;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
    repeat (6) tick();
  endtask
  task automatic rnd_beat();
    rd = 16'($urandom);
    rs = 4'($urandom);
    rm = 2'($urandom);
  endtask
  initial begin
    v[0]  = '{16'h8001, 4'd1,  LSR, 16'h4000};
    v[1]  = '{16'h8001, 4'd4,  LSL, 16'h0010};
    v[2]  = '{16'h8000, 4'd3,  ASR, 16'hF000};
    v[3]  = '{16'h4000, 4'd3,  ASR, 16'h0800};
    v[4]  = '{16'h0001, 4'd1,  ROR, 16'h8000};
    v[5]  = '{16'h1234, 4'd15, ROR, 16'h2468};
    v[6]  = '{16'h1234, 4'd0,  ROR, 16'h1234};
    v[7]  = '{16'h8001, 4'd15, ASR, 16'hFFFF};
    v[8]  = '{16'hABCD, 4'd0,  LSR, 16'hABCD};
    v[9]  = '{16'hABCD, 4'd15, LSL, 16'h8000};
    v[10] = '{16'hABCD, 4'd15, LSR, 16'h0001};
    v[11] = '{16'h7FFF, 4'd15, ASR, 16'h0000};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    foreach (v[i]) send(v[i].d, v[i].sh, v[i].m, v[i].exp);
    drain();
    out_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      rnd_beat();
      send(rd, rs, rm, model(rd, rs, rm));
    end
    drain();
    chk("stream_count", out_cnt, 16);
    chk("stream_span", last_cyc - first_cyc, 15);
    lat_chk = 1'b0;
    out_ready = 1'b0;
    out_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rnd_beat();
      send(rd, rs, rm, model(rd, rs, rm));
    end
    rnd_beat();
    in_valid = 1'b1;
    in_data  = rd;
    in_shamt = rs;
    in_mode  = rm;
    drv_exp  = model(rd, rs, rm);
    held = out_data;
    chk("bp_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    send(rd, rs, rm, model(rd, rs, rm));
    drain();
    chk("bp_count", out_cnt, 5);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) tick();
      rnd_beat();
      send(rd, rs, rm, model(rd, rs, rm));
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    out_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      rnd_beat();
      send(rd, rs, rm, model(rd, rs, rm));
    end
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_shamt = 4'd1;
    in_mode  = 2'b00;
    drv_exp  = 16'h7FFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_data", 32'(out_data), 0);
    repeat (10) tick();
    chk("mid_rst_no_stale", out_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
